// File: rtl/ccu_phase_sequencer.sv
// ccu_phase_sequencer: turns the CCU phase count into one-hot fetch/decode/execute/writeback strobes
//
// Sits downstream of the 2-bit phase counter. It checks that the count advances
// 0,1,2,3,0..., produces a registered strobe one cycle after each accepted
// phase, counts completed writebacks, and holds the counter at fetch (through
// the combinational stall output) until memory is ready.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   phase[1:0]   phase counter value (0 fetch, 1 decode, 2 execute, 3 writeback)
//   start        leave IDLE / continue after writeback
//   mem_ready    memory ready, required to complete fetch
//   stall        combinational hold request back to the phase counter
//   fetch_en, decode_en, exec_en, wb_en   registered one-hot strobes
//   busy         high in SYNC, RUN and STALL
//   cycle_cnt    completed writebacks, wraps modulo 2^CNT_W
//   phase_err    sticky out-of-sequence flag, cleared by start from IDLE
//   timeout_err  sticky stall-timeout flag, cleared by start from IDLE
//
// Build option: define CCU_STALL_TIMEOUT_EN to abandon a fetch stall after
// TIMEOUT cycles in STALL; otherwise STALL waits indefinitely and timeout_err
// is tied low.
module ccu_phase_sequencer #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       phase,
    input  logic             start,
    input  logic             mem_ready,
    output logic             stall,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             wb_en,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             phase_err,
    output logic             timeout_err
);

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("TIMEOUT must be at least 1");
    end
    if (CNT_W < 1) begin : g_cnt_chk
        $error("CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SYNC, RUN, STALL} state_t;

    state_t           state, state_nx;
    logic [1:0]       exp_q, exp_nx;
    logic [1:0]       exp_ref;
    logic [3:0]       str_q, str_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             perr_nx;

`ifdef CCU_STALL_TIMEOUT_EN
    localparam int SC_W = $clog2(TIMEOUT + 1);
    logic [SC_W-1:0] sc_q, sc_nx;
    logic            terr_q, terr_nx;
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    // SYNC always lines up on a fetch, whatever exp was left at.
    assign exp_ref = (state == SYNC) ? 2'd0 : exp_q;

    assign stall = !mem_ready &&
                   ((((state == SYNC) || (state == RUN)) && (phase == 2'd0)) || (state == STALL));

    assign {wb_en, exec_en, decode_en, fetch_en} = str_q;
    assign busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        exp_nx   = exp_q;
        str_nx   = '0;
        cnt_nx   = cycle_cnt;
        perr_nx  = phase_err;
`ifdef CCU_STALL_TIMEOUT_EN
        sc_nx    = sc_q;
        terr_nx  = terr_q;
`endif
        if (state == IDLE) begin
            if (start) begin
                state_nx = SYNC;
                perr_nx  = 1'b0;
`ifdef CCU_STALL_TIMEOUT_EN
                terr_nx  = 1'b0;
`endif
            end
        end else if ((state != SYNC) || (phase == 2'd0)) begin
            // The sequence check outranks stall handling and start.
            if (phase != exp_ref) begin
                perr_nx  = 1'b1;
                state_nx = IDLE;
                exp_nx   = 2'd0;
            end else if ((phase == 2'd0) && !mem_ready) begin
                if (state != STALL) begin
                    state_nx = STALL;
`ifdef CCU_STALL_TIMEOUT_EN
                    sc_nx    = '0;
`endif
                end
`ifdef CCU_STALL_TIMEOUT_EN
                else if (sc_q == SC_W'(TIMEOUT - 1)) begin
                    terr_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    sc_nx = sc_q + SC_W'(1);
                end
`endif
            end else begin
                str_nx = 4'b0001 << phase;
                exp_nx = phase + 2'd1;
                if (phase == 2'd3) begin
                    cnt_nx   = cycle_cnt + CNT_W'(1);
                    state_nx = start ? RUN : IDLE;
                end else begin
                    state_nx = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            exp_q     <= 2'd0;
            str_q     <= '0;
            cycle_cnt <= '0;
            phase_err <= 1'b0;
        end else begin
            state     <= state_nx;
            exp_q     <= exp_nx;
            str_q     <= str_nx;
            cycle_cnt <= cnt_nx;
            phase_err <= perr_nx;
        end
    end

`ifdef CCU_STALL_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sc_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            sc_q   <= sc_nx;
            terr_q <= terr_nx;
        end
    end
`endif

endmodule

// File: tb/tb_ccu_phase_sequencer.sv
// tb_ccu_phase_sequencer: directed, model-checked bench for ccu_phase_sequencer
module tb_ccu_phase_sequencer;

    localparam int TO = 16;
`ifdef CCU_STALL_TIMEOUT_EN
    localparam bit TOEN = 1'b1;
`else
    localparam bit TOEN = 1'b0;
`endif
    localparam int M_IDLE = 0, M_SYNC = 1, M_RUN = 2, M_STALL = 3;

    logic       clk = 1'b1;
    logic       reset = 1'b0;
    logic [1:0] phase = 2'd0;
    logic       start = 1'b0;
    logic       mem_ready = 1'b1;

    logic       stall, fetch_en, decode_en, exec_en, wb_en, busy, phase_err, timeout_err;
    logic [7:0] cycle_cnt;
    logic       stall2, fetch_en2, decode_en2, exec_en2, wb_en2, busy2, phase_err2, timeout_err2;
    logic [1:0] cycle_cnt2;

    ccu_phase_sequencer #(.CNT_W(8), .TIMEOUT(TO)) u_dut (
        .clk(clk), .reset(reset), .phase(phase), .start(start), .mem_ready(mem_ready),
        .stall(stall), .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
        .wb_en(wb_en), .busy(busy), .cycle_cnt(cycle_cnt), .phase_err(phase_err),
        .timeout_err(timeout_err)
    );

    ccu_phase_sequencer #(.CNT_W(2), .TIMEOUT(TO)) u_dut2 (
        .clk(clk), .reset(reset), .phase(phase), .start(start), .mem_ready(mem_ready),
        .stall(stall2), .fetch_en(fetch_en2), .decode_en(decode_en2), .exec_en(exec_en2),
        .wb_en(wb_en2), .busy(busy2), .cycle_cnt(cycle_cnt2), .phase_err(phase_err2),
        .timeout_err(timeout_err2)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: mode, expected next phase, strobe index (-1 none),
    // completed writebacks, sticky flags, cycles spent stalled.
    int m_mode = M_IDLE;
    int m_exp = 0;
    int m_str = -1;
    int m_cnt = 0;
    int m_perr = 0;
    int m_terr = 0;
    int m_sc = 0;
    int m_want = 0;

    function automatic bit m_stall();
        return !mem_ready && ((((m_mode == M_SYNC) || (m_mode == M_RUN)) && (phase == 2'd0)) ||
                              (m_mode == M_STALL));
    endfunction

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_mode = M_IDLE; m_exp = 0; m_str = -1; m_cnt = 0; m_perr = 0; m_terr = 0; m_sc = 0;
        end else begin
            m_str = -1;
            if (m_mode == M_IDLE) begin
                if (start) begin
                    m_mode = M_SYNC; m_perr = 0; m_terr = 0;
                end
            end else if (!(m_mode == M_SYNC && phase != 2'd0)) begin
                m_want = (m_mode == M_SYNC) ? 0 : m_exp;
                if (int'(phase) != m_want) begin
                    m_perr = 1; m_mode = M_IDLE; m_exp = 0;
                end else if (phase == 2'd0 && !mem_ready) begin
                    if (m_mode != M_STALL) begin
                        m_mode = M_STALL; m_sc = 0;
                    end else begin
                        m_sc++;
                        if (TOEN && m_sc == TO) begin
                            m_terr = 1; m_mode = M_IDLE;
                        end
                    end
                end else begin
                    m_str = int'(phase);
                    m_exp = (int'(phase) + 1) % 4;
                    if (phase == 2'd3) begin
                        m_cnt++;
                        m_mode = start ? M_RUN : M_IDLE;
                    end else begin
                        m_mode = M_RUN;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("stall", stall, m_stall());
        chk("strobes", {wb_en, exec_en, decode_en, fetch_en}, (m_str < 0) ? 0 : (1 << m_str));
        chk("busy", busy, m_mode != M_IDLE);
        chk("cycle_cnt", cycle_cnt, m_cnt % 256);
        chk("cycle_cnt_w2", cycle_cnt2, m_cnt % 4);
        chk("phase_err", phase_err, m_perr);
        chk("timeout_err", timeout_err, m_terr);
    end

    bit last_stall;

    // One clock acting as the phase counter: it advances unless stall is requested.
    task automatic step(input bit st, input bit mr);
        bit adv;
        start = st;
        mem_ready = mr;
        #2;
        last_stall = stall;
        adv = !m_stall();
        @(posedge clk);
        #1;
        if (adv) phase = phase + 2'd1;
    endtask

    task automatic force_ph(input logic [1:0] p, input bit st, input bit mr);
        phase = p;
        start = st;
        mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_fetch();
        int k = 0;
        while (!(phase == 2'd0 && (m_mode == M_SYNC || m_mode == M_RUN)) && k < 40) begin
            step(1'b1, 1'b1);
            k++;
        end
        chk("reach_fetch", k < 40, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf = 0, nd = 0, ne = 0, nw = 0, ns = 0, k = 0, got = 0, last = 0;
        int q[5];
        int wexp[5] = '{1, 2, 3, 0, 1};
        #15 reset = 1'b1;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_strobes", {wb_en, exec_en, decode_en, fetch_en}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cycle_cnt, 0);
        chk("rst_perr", phase_err, 0);
        chk("rst_terr", timeout_err, 0);
        @(posedge clk);
        #1;

        while (m_cnt < 3 && k < 60) begin
            step(!(phase == 2'd3 && m_cnt == 2), 1'b1);
            nf += fetch_en; nd += decode_en; ne += exec_en; nw += wb_en;
            k++;
        end
        chk("nom_fetch", nf, 3);
        chk("nom_decode", nd, 3);
        chk("nom_exec", ne, 3);
        chk("nom_wb", nw, 3);
        chk("nom_cnt", cycle_cnt, 3);
        chk("nom_cnt_w2", cycle_cnt2, 3);
        chk("nom_busy", busy, 0);
        chk("nom_last_wb", wb_en, 1);

        run_to_fetch();
        ns = 0;
        repeat (4) begin
            step(1'b1, 1'b0);
            ns += int'(last_stall);
            chk("stall_no_fetch", fetch_en, 0);
        end
        chk("stall_cycles", ns, 4);
        step(1'b1, 1'b1);
        chk("stall_fetch", fetch_en, 1);
        step(1'b1, 1'b1);
        chk("stall_decode", decode_en, 1);

        run_to_fetch();
        force_ph(2'd0, 1'b1, 1'b1);
        force_ph(2'd1, 1'b1, 1'b1);
        force_ph(2'd3, 1'b1, 1'b1);
        chk("perr_set", phase_err, 1);
        chk("perr_busy", busy, 0);
        chk("perr_cnt", cycle_cnt, 4);
        chk("perr_no_wb", wb_en, 0);
        step(1'b1, 1'b1);
        chk("perr_clear", phase_err, 0);

        run_to_fetch();
`ifdef CCU_STALL_TIMEOUT_EN
        ns = 0;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b0);
            ns += int'(last_stall);
            if (i == 15) chk("to_not_yet", timeout_err, 0);
        end
        chk("to_err", timeout_err, 1);
        chk("to_busy", busy, 0);
        chk("to_stall_cycles", ns, 17);
        #1;
        chk("to_stall_drop", stall, 0);
        run_to_fetch();
        chk("to_err_cleared", timeout_err, 0);
        repeat (16) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("to_edge_fetch", fetch_en, 1);
        chk("to_edge_err", timeout_err, 0);
`else
        ns = 0;
        repeat (20) begin
            step(1'b1, 1'b0);
            ns += int'(last_stall);
        end
        chk("nto_stall_cycles", ns, 20);
        chk("nto_err", timeout_err, 0);
        chk("nto_busy", busy, 1);
        step(1'b1, 1'b1);
        chk("nto_fetch", fetch_en, 1);
`endif

        run_to_fetch();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_strobes", {wb_en, exec_en, decode_en, fetch_en}, 0);
        chk("mid_rst_cnt", cycle_cnt, 0);
        chk("mid_rst_cnt_w2", cycle_cnt2, 0);
        chk("mid_rst_stall", stall, 0);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        k = 0;
        last = m_cnt;
        while (got < 5 && k < 60) begin
            step(1'b1, 1'b1);
            if (m_cnt != last) begin
                q[got] = int'(cycle_cnt2);
                got++;
                last = m_cnt;
            end
            k++;
        end
        chk("wrap_done", got, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("wrap_seq%0d", i), q[i], wexp[i]);

        #20;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/ccu_phase_sequencer.md
Name: ccu_phase_sequencer

Overview:
- Sits directly downstream of the CCU 2-bit phase counter and consumes its count value.
- Turns the count into registered one-hot control strobes for a four-phase instruction cycle: fetch, decode, execute, writeback.
- Checks that the counter advances in sequence and counts completed instruction cycles.
- During fetch, holds the counter through a combinational stall request until memory is ready.

Parameters:
- CNT_W, 8, width of the completed-cycle counter.
- TIMEOUT, 16, maximum stall cycles before timeout. Used only with CCU_STALL_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; the block is held in reset while it is 0.
- phase  input  2  count value from the phase counter (0 = fetch, 1 = decode, 2 = execute, 3 = writeback).
- start  input  1  begin a cycle from IDLE; sampled at writeback to decide whether to continue.
- mem_ready  input  1  memory ready; needed to complete fetch.
- stall  output  1  combinational hold request to the phase counter.
- fetch_en  output  1  registered strobe.
- decode_en  output  1  registered strobe.
- exec_en  output  1  registered strobe.
- wb_en  output  1  registered strobe.
- busy  output  1  high in SYNC, RUN and STALL.
- cycle_cnt  output  CNT_W  number of completed writebacks; wraps modulo 2^CNT_W.
- phase_err  output  1  sticky sequence-error flag.
- timeout_err  output  1  sticky stall-timeout flag.

Behaviour:
- Reset (reset=0, asynchronous, also mid-operation):
  - State goes to IDLE; the internal expected-phase register exp goes to 0.
  - All strobes, busy, cycle_cnt, phase_err and timeout_err go to 0.
  - stall evaluates to 0.
- The four strobes are one-hot or all zero. Each strobe is high for exactly one cycle, starting the cycle after the edge on which its phase was accepted (latency 1).
- IDLE:
  - busy=0, strobes=0.
  - start=1 → SYNC. On that edge phase_err and timeout_err are cleared.
- SYNC:
  - Waits for phase==0.
  - On phase==0 it handles fetch exactly as RUN does with exp=0. Other phase values are ignored; they are not errors.
- RUN, each edge:
  - phase≠exp → phase_err=1, state IDLE, strobes 0, cycle_cnt unchanged.
  - phase==0, mem_ready=1 → fetch_en next cycle, exp=1.
  - phase==0, mem_ready=0 → state STALL, no strobe, exp stays 0.
  - phase==1 → decode_en, exp=2.
  - phase==2 → exec_en, exp=3.
  - phase==3 → wb_en, cycle_cnt+1, exp=0. Then start=1 → stay in RUN; start=0 → IDLE.
- STALL:
  - stall is combinational: stall = mem_ready==0 AND ((state is SYNC or RUN with phase==0) OR state is STALL). The counter therefore holds on the same edge.
  - While in STALL, phase≠0 → phase_err=1, state IDLE.
  - mem_ready=1 → fetch_en next cycle, exp=1, state RUN.
- Simultaneous events: the phase mismatch check has priority over the stall handling and over start.
- Writeback with start=0 still asserts wb_en and increments cycle_cnt.
- Wrap-around: exp wraps 3→0. cycle_cnt wraps from 2^CNT_W−1 to 0 with no flag.
- Outside STALL, stall is 0 except at the fetch edge described above.

Optional Feature:
- Macro: CCU_STALL_TIMEOUT_EN.
- Defined:
  - A stall counter resets to 0 on entry to STALL and increments once per cycle spent in STALL.
  - When it reaches TIMEOUT with mem_ready still 0: timeout_err=1 (sticky), state IDLE, stall drops next cycle.
  - mem_ready=1 on that same edge wins: fetch proceeds and no timeout is raised.
- Undefined:
  - STALL persists indefinitely.
  - timeout_err is tied to 0; the port is still present.

Test Plan (10 ns clock):
- Reset: reset=0 at t=0, release at t=15 → all outputs 0, state IDLE. Reassert reset mid-RUN → outputs return to 0 immediately, without waiting for an edge.
- Nominal run: start=1, mem_ready=1, counter free-running 0,1,2,3,0... → fetch, decode, exec, wb strobes one-hot, each one cycle after its phase. cycle_cnt=3 after 3 full cycles. With start=0 at the third writeback → back to IDLE, busy=0.
- Fetch stall: mem_ready=0 for 4 cycles at phase 0 → stall=1 for those 4 cycles, counter held at 0, no strobes. mem_ready=1 → fetch_en on the next cycle, then decode follows.
- Sequence error: force phase 0,1,3 → phase_err=1 after the edge sampling 3, state IDLE, cycle_cnt unchanged. A new start pulse clears phase_err.
- Wrap-around: CNT_W=2, run 5 full cycles → cycle_cnt sequence 1,2,3,0,1.
- Timeout (CCU_STALL_TIMEOUT_EN, TIMEOUT=16):
  - mem_ready held at 0 → timeout_err=1 after the 16th STALL cycle, busy=0.
  - mem_ready=1 exactly on the 16th edge → fetch_en, timeout_err stays 0.
  - Without the macro: timeout_err stays 0 and stall stays 1.
